// File: rtl/mul16_ctrl_pkg.sv
// Shared sizing constants for the arbitrated mul16 pipeline.
// Imported by the arbiter, the multiplier and the top.
package mul16_ctrl_pkg;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int OPW  = 16;
  localparam int PW   = 32;
endpackage

// File: rtl/mul16_evo218.sv
// Approximate 16x16 multiplier: partial-product bits whose column
// weight is below 2^8 are dropped, with no compensation term.
module mul16_evo218
  import mul16_ctrl_pkg::*;
(
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic [PW-1:0]  c
);

  logic [OPW-1:0] keep;

  always_comb begin
    c    = '0;
    keep = '0;
    for (int j = 0; j < OPW; j++) begin
      keep = (j >= 8) ? {OPW{1'b1}} : ({OPW{1'b1}} << (8 - j));
      if (b[j])
        c = c + (PW'(a & keep) << j);
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Combinational round-robin grant for four requesters.
// Search starts at ptr and wraps upward; en gates every grant.
module rr_arb4
  import mul16_ctrl_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_any
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr + IDW'(i);
      if (en && !gnt_any && valid[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mul16_arbiter.sv
// Four requesters share one approximate multiplier through a
// round-robin grant and a two-stage valid/ready pipeline.
module mul16_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [31:0]       rsp_c,
  output logic              busy
);
  import mul16_ctrl_pkg::*;

  logic           s1_v, s2_v;
  logic [OPW-1:0] s1_a, s1_b;
  logic [IDW-1:0] s1_id, ptr, gnt_id;
  logic [PW-1:0]  prod;
  logic           gnt_any, s2_load, s1_free;

  assign rsp_valid = s2_v;
  assign s2_load   = !s2_v || rsp_ready;
  assign s1_free   = !s1_v || s2_load;
  assign busy      = s1_v || s2_v;

  rr_arb4 u_arb (
    .valid   (req_valid),
    .ptr     (ptr),
    .en      (s1_free),
    .gnt     (req_ready),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  mul16_evo218 u_mul (
    .a (s1_a),
    .b (s1_b),
    .c (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v   <= 1'b0;
      s2_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
      ptr    <= '0;
      rsp_c  <= '0;
      rsp_id <= '0;
    end else begin
      if (s2_load) begin
        s2_v <= s1_v;
        if (s1_v) begin
          rsp_c  <= prod;
          rsp_id <= s1_id;
        end
      end
      // An empty grant while S1 advances leaves a bubble behind.
      if (s1_free) begin
        s1_v <= gnt_any;
        if (gnt_any) begin
          s1_a  <= req_a[int'(gnt_id)*OPW +: OPW];
          s1_b  <= req_b[int'(gnt_id)*OPW +: OPW];
          s1_id <= gnt_id;
        end
      end
      if (gnt_any)
        ptr <= gnt_id + IDW'(1);
    end
  end

endmodule
